// File: rtl/sd_card_cmd_responder_pkg.sv
// Shared constants, state encodings and frame layout for the SD CMD-line responder.
package sd_card_cmd_responder_pkg;

  localparam int unsigned CMD_LEN         = 48;
  localparam int unsigned LONG_LEN        = 136;
  localparam int unsigned NCR_CYCLES      = 2;
  localparam int unsigned WAIT_LIMIT      = 64;
  localparam int unsigned CRC_LEN         = 7;
  localparam int unsigned CRC_SPAN        = 40;
  localparam int unsigned CRC_IDX_W       = 3;
  localparam int unsigned RESP_W          = 127;
  localparam int unsigned SHORT_PAYLOAD_W = 38;
  localparam int unsigned INDEX_W         = 6;
  localparam int unsigned ARG_W           = 32;
  localparam int unsigned BIT_CNT_W       = 8;
  localparam int unsigned WAIT_CNT_W      = 7;

  localparam logic [CRC_LEN-1:0] CRC_POLY = 7'h09;

  typedef enum logic [6:0] {
    ST_IDLE      = 7'b0000001,
    ST_RECEIVE   = 7'b0000010,
    ST_CHECK     = 7'b0000100,
    ST_WAIT_CARD = 7'b0001000,
    ST_NCR       = 7'b0010000,
    ST_SEND      = 7'b0100000,
    ST_DONE      = 7'b1000000
  } state_t;

  // Host-to-card command frame as it sits in the receive shifter.
  typedef struct packed {
    logic               start;
    logic               dir;
    logic [INDEX_W-1:0] index;
    logic [ARG_W-1:0]   arg;
    logic [CRC_LEN-1:0] crc;
    logic               stop;
  } frame_t;

endpackage

// File: rtl/sd_card_cmd_responder_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB first, shared by receive check and transmit generation.
module sd_crc7
  import sd_card_cmd_responder_pkg::*;
(
  input  logic               sd_clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic               data_in,
  output logic [CRC_LEN-1:0] crc
);

  logic feedback;

  assign feedback = data_in ^ crc[CRC_LEN-1];

  // LFSR update; clear has priority over enable.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[CRC_LEN-2:0], 1'b0} ^ (feedback ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// SD card CMD-line responder: receives 48-bit commands, hands them to card logic,
// and serialises the short (48-bit) or long (136-bit) response back onto the line.
module sd_card_cmd_responder
  import sd_card_cmd_responder_pkg::*;
(
  input  logic               sd_clock,
  input  logic               reset,
  input  logic               cmd_in,
  output logic               cmd_out,
  output logic               pad_state,
  output logic               pad_enable,
  output logic [INDEX_W-1:0] cmd_index,
  output logic [ARG_W-1:0]   cmd_arg,
  output logic               cmd_strobe,
  input  logic               cmd_ack,
  input  logic               resp_strobe,
  input  logic               resp_none,
  input  logic               resp_long,
  input  logic [RESP_W-1:0]  resp_data,
  output logic               crc_error,
  output logic               resp_timeout,
  output logic               resp_done
);

  state_t                  state, state_nxt;
  logic [CMD_LEN-1:0]      rx_shift, rx_shift_nxt;
  logic [LONG_LEN-1:0]     tx_shift, tx_shift_nxt;
  logic                    tx_long, tx_long_nxt;
  logic [BIT_CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [WAIT_CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic                    drive_nxt;
  logic                    cmd_out_nxt;
  logic [INDEX_W-1:0]      cmd_index_nxt;
  logic [ARG_W-1:0]        cmd_arg_nxt;
  logic                    cmd_strobe_nxt;
  logic                    crc_error_nxt;
  logic                    resp_timeout_nxt;
  logic                    resp_done_nxt;

  logic                    crc_clear;
  logic                    crc_enable;
  logic                    crc_bit;
  logic [CRC_LEN-1:0]      crc_val;
  logic                    emit;
  logic                    tx_bit;
  logic                    in_crc_field;
  logic [CRC_IDX_W-1:0]    crc_idx;
  logic [BIT_CNT_W-1:0]    last_idx;
  logic                    frame_ok;
  frame_t                  rx_frame;

  sd_crc7 u_crc7 (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clear    (crc_clear),
    .enable   (crc_enable),
    .data_in  (crc_bit),
    .crc      (crc_val)
  );

  // Received-frame decode and transmit bit selection (CRC field of short responses comes from the generator).
  assign rx_frame     = frame_t'(rx_shift);
  assign frame_ok     = !rx_frame.start && rx_frame.dir && rx_frame.stop && (crc_val == rx_frame.crc);
  assign in_crc_field = !tx_long && (bit_cnt >= BIT_CNT_W'(CRC_SPAN)) && (bit_cnt < BIT_CNT_W'(CMD_LEN - 1));
  assign crc_idx      = CRC_IDX_W'(BIT_CNT_W'(CMD_LEN - 2) - bit_cnt);
  assign tx_bit       = in_crc_field ? crc_val[crc_idx] : tx_shift[LONG_LEN-1];
  assign last_idx     = tx_long ? BIT_CNT_W'(LONG_LEN - 1) : BIT_CNT_W'(CMD_LEN - 1);

  // State and registered-output update.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      rx_shift     <= '0;
      tx_shift     <= '0;
      tx_long      <= 1'b0;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      pad_state    <= 1'b0;
      pad_enable   <= 1'b0;
      cmd_out      <= 1'b1;
      cmd_index    <= '0;
      cmd_arg      <= '0;
      cmd_strobe   <= 1'b0;
      crc_error    <= 1'b0;
      resp_timeout <= 1'b0;
      resp_done    <= 1'b0;
    end else begin
      state        <= state_nxt;
      rx_shift     <= rx_shift_nxt;
      tx_shift     <= tx_shift_nxt;
      tx_long      <= tx_long_nxt;
      bit_cnt      <= bit_cnt_nxt;
      wait_cnt     <= wait_cnt_nxt;
      pad_state    <= drive_nxt;
      pad_enable   <= drive_nxt;
      cmd_out      <= cmd_out_nxt;
      cmd_index    <= cmd_index_nxt;
      cmd_arg      <= cmd_arg_nxt;
      cmd_strobe   <= cmd_strobe_nxt;
      crc_error    <= crc_error_nxt;
      resp_timeout <= resp_timeout_nxt;
      resp_done    <= resp_done_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt        = state;
    rx_shift_nxt     = rx_shift;
    tx_shift_nxt     = tx_shift;
    tx_long_nxt      = tx_long;
    bit_cnt_nxt      = bit_cnt;
    wait_cnt_nxt     = wait_cnt;
    drive_nxt        = pad_enable;
    cmd_out_nxt      = cmd_out;
    cmd_index_nxt    = cmd_index;
    cmd_arg_nxt      = cmd_arg;
    cmd_strobe_nxt   = 1'b0;
    crc_error_nxt    = 1'b0;
    resp_timeout_nxt = 1'b0;
    resp_done_nxt    = 1'b0;
    crc_clear        = 1'b0;
    crc_enable       = 1'b0;
    crc_bit          = 1'b0;
    emit             = 1'b0;

    case (state)
      ST_IDLE: begin
        // A zero start bit leaves a cleared CRC unchanged, so clearing here also covers bit 0.
        crc_clear   = 1'b1;
        drive_nxt   = 1'b0;
        cmd_out_nxt = 1'b1;
        if (!cmd_in) begin
          rx_shift_nxt = {rx_shift[CMD_LEN-2:0], 1'b0};
          bit_cnt_nxt  = BIT_CNT_W'(1);
          state_nxt    = ST_RECEIVE;
        end
      end

      ST_RECEIVE: begin
        rx_shift_nxt = {rx_shift[CMD_LEN-2:0], cmd_in};
        crc_bit      = cmd_in;
        crc_enable   = (bit_cnt < BIT_CNT_W'(CRC_SPAN));
        bit_cnt_nxt  = bit_cnt + 1'b1;
        if (bit_cnt == BIT_CNT_W'(CMD_LEN - 1)) begin
          state_nxt = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (!frame_ok) begin
          crc_error_nxt = 1'b1;
          state_nxt     = ST_IDLE;
        end else if (cmd_strobe && cmd_ack) begin
          wait_cnt_nxt = '0;
          state_nxt    = ST_WAIT_CARD;
        end else begin
          cmd_index_nxt  = rx_frame.index;
          cmd_arg_nxt    = rx_frame.arg;
          cmd_strobe_nxt = 1'b1;
        end
      end

      ST_WAIT_CARD: begin
        crc_clear = 1'b1;
        if (resp_strobe) begin
          if (resp_none) begin
            state_nxt = ST_IDLE;
          end else begin
            tx_long_nxt  = resp_long;
            tx_shift_nxt = resp_long
                         ? {2'b00, 6'b111111, resp_data, 1'b1}
                         : {2'b00, resp_data[SHORT_PAYLOAD_W-1:0], {CRC_LEN{1'b0}}, 1'b1,
                            {(LONG_LEN - CMD_LEN){1'b0}}};
            wait_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
            drive_nxt    = 1'b1;
            cmd_out_nxt  = 1'b1;
            state_nxt    = ST_NCR;
          end
        end else if (wait_cnt == WAIT_CNT_W'(WAIT_LIMIT - 1)) begin
          resp_timeout_nxt = 1'b1;
          state_nxt        = ST_IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end

      ST_NCR: begin
        // Last NCR cycle already launches bit 0 so the line stays high for exactly NCR_CYCLES.
        if (wait_cnt == WAIT_CNT_W'(NCR_CYCLES - 1)) begin
          emit = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
          cmd_out_nxt  = 1'b1;
        end
      end

      ST_SEND: begin
        emit = 1'b1;
      end

      ST_DONE: begin
        drive_nxt     = 1'b0;
        cmd_out_nxt   = 1'b1;
        resp_done_nxt = 1'b1;
        state_nxt     = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Launch one response bit; the CRC generator sees the first CRC_SPAN bits.
    if (emit) begin
      cmd_out_nxt  = tx_bit;
      tx_shift_nxt = {tx_shift[LONG_LEN-2:0], 1'b0};
      crc_bit      = tx_shift[LONG_LEN-1];
      crc_enable   = (bit_cnt < BIT_CNT_W'(CRC_SPAN));
      bit_cnt_nxt  = bit_cnt + 1'b1;
      state_nxt    = (bit_cnt == last_idx) ? ST_DONE : ST_SEND;
    end
  end

endmodule

// File: doc/sd_card_cmd_responder.md
SD_CARD_CMD_RESPONDER -- requirements
Module: sd_card_cmd_responder

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 SHALL have port sd_clock  input  1  card clock; all flops on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cmd_in  input  1  serial CMD line from pad; idle high.
REQ-005 SHALL have port cmd_out  output  1  serial CMD data to pad.
REQ-006 SHALL have port pad_state  output  1  1 = pad drives (output), 0 = pad receives (input).
REQ-007 SHALL have port pad_enable  output  1  pad driver enable.
REQ-008 SHALL have port cmd_index  output  6  received command index.
REQ-009 SHALL have port cmd_arg  output  32  received command argument.
REQ-010 SHALL have port cmd_strobe  output  1  valid command for card logic.
REQ-011 SHALL have port cmd_ack  input  1  card logic has taken the command.
REQ-012 SHALL have port resp_strobe  input  1  response ready from card logic.
REQ-013 SHALL have port resp_none  input  1  with resp_strobe: send no response.
REQ-014 SHALL have port resp_long  input  1  with resp_strobe: 136-bit R2 response, else 48-bit.
REQ-015 SHALL have port resp_data  input  127  long: bits 126:0 sent verbatim; short: bits 37:0 = index and argument.
REQ-016 SHALL have port crc_error  output  1  one-cycle pulse on a bad received frame.
REQ-017 SHALL have port resp_timeout  output  1  one-cycle pulse when card logic never answers.
REQ-018 SHALL have port resp_done  output  1  one-cycle pulse after the last response bit.

Function
REQ-019 SHALL use one-hot states IDLE, RECEIVE, CHECK, WAIT_CARD, NCR, SEND, DONE.
REQ-020 SHALL leave IDLE when cmd_in samples 0 (start bit), then shift 47 more bits, MSB first, in RECEIVE.
REQ-021 SHALL enter CHECK after bit 48 and set crc_error = 1 for one cycle, then return to IDLE with no strobe, if any check fails:
- transmission bit != 1
- end bit != 1
- CRC7 (x^7+x^3+1, over the first 40 bits) != received CRC
REQ-022 SHALL, on a good frame, load cmd_index and cmd_arg, hold cmd_strobe = 1 until cmd_ack is sampled 1, then move to WAIT_CARD.
REQ-023 SHALL, in WAIT_CARD, count up to 64 cycles for resp_strobe; on expiry pulse resp_timeout and return to IDLE.
REQ-024 SHALL return to IDLE without driving the line when resp_strobe and resp_none are both 1.
REQ-025 SHALL otherwise latch resp_long and resp_data, then enter NCR: pad_state = 1, pad_enable = 1, cmd_out = 1 for exactly 2 cycles.
REQ-026 SHALL send the short response as 0, 0, index[5:0], arg[31:0], CRC7, 1 (48 bits, CRC computed internally).
REQ-027 SHALL send the long response as 0, 0, 111111, resp_data[126:0], 1 (136 bits).
REQ-028 SHALL, in DONE, pulse resp_done, force pad_enable = 0, pad_state = 0 and cmd_out = 1, then go to IDLE.
REQ-029 SHALL ignore cmd_in in every state except IDLE and RECEIVE; a command that arrives during a response is not seen.
REQ-030 SHALL NOT restart a frame on a 0 seen mid-RECEIVE; the bit counter alone defines frame length.

Reset
REQ-031 SHALL, while reset = 0, force state = IDLE, cmd_out = 1, pad_state = 0, pad_enable = 0, cmd_index = 0, cmd_arg = 0, and clear all strobes and pulses and all counters.
REQ-032 SHALL abort any transfer on reset mid-frame, release the pad immediately, and not resume the transfer.

Structure
REQ-033 SHALL place in the shared package: state encodings, CMD_LEN = 48, LONG_LEN = 136, NCR_CYCLES = 2, WAIT_LIMIT = 64.
REQ-034 SHALL instantiate one sub-module, sd_crc7, a serial CRC7 generator with clear and enable, reused for receive check and transmit generation.

Verification
REQ-035 SHALL cover: CMD0 frame 0x400000000095 -> cmd_strobe with cmd_index = 0, cmd_arg = 0, no crc_error.
REQ-036 SHALL cover: CMD8 frame 0x48000001AA87, ack, then short response with resp_data = {8, 0x1AA} -> after 2 NCR high bits, cmd_out serialises 0x08000001AA13, then resp_done.
REQ-037 SHALL cover: CMD8 frame with CRC byte 0x89 -> crc_error pulse, no cmd_strobe, pad_enable stays 0.
REQ-038 SHALL cover: good frame, ack, no resp_strobe for 64 cycles -> resp_timeout pulse, back to IDLE.
REQ-039 SHALL cover: long response with resp_data all ones -> 136 bits starting 00111111, ending 1; pad released in DONE.
REQ-040 SHALL cover: reset asserted at bit 20 of SEND -> cmd_out = 1 and pad_enable = 0 at once; the next frame is accepted normally.
